pingpong_frame_buf: RTL and testbench
=====================================

# pingpong_frame_buf

Parametrised ping-pong frame buffer. It collects a stream of DATA_W-bit samples into DEPTH-sample frames, alternating between two banks, and presents each completed frame as one wide parallel word with a valid/ready handshake. Capture into one bank continues while the consumer holds the other. It sits between a serial/sample front end and the downstream block-processing logic (e.g. the symmetric FIR coefficient/sample loader). It adds partial-frame flush and backpressure, or a compile-time drop mode.

## Interface
- DATA_W, 1, bits per sample
- DEPTH, 512, samples per frame (≥2)
- LEN_W, $clog2(DEPTH+1), width of out_len
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present
- in_data  in  DATA_W  sample
- in_ready  out  1  sample accepted when in_valid && in_ready
- flush  in  1  single-cycle request to close the current partial frame
- out_valid  out  1  frame available
- out_ready  in  1  consumer takes frame when out_valid && out_ready
- out_frame  out  DEPTH*DATA_W  sample k at bits [k*DATA_W +: DATA_W]
- out_len  out  LEN_W  valid samples in out_frame (1..DEPTH)
- out_bank  out  1  bank index of presented frame
- drop_cnt  out  16  dropped-sample count (only with PPBUF_DROP_EN)

## Operation
- State: two banks of DEPTH×DATA_W, full[1:0], len0/len1, wr_sel, wr_idx (0..DEPTH-1), rd_sel.
- Reset (async, rst_n=0): banks cleared to 0; full=0, wr_sel=0, rd_sel=0, wr_idx=0. Outputs: in_ready=1, out_valid=0, out_frame=0, out_len=0, out_bank=0, drop_cnt=0.
- in_ready = !full[wr_sel].
- Accept: bank[wr_sel][wr_idx] <= in_data; wr_idx++.
- Frame complete (accept with wr_idx==DEPTH-1): full[wr_sel]<=1, len[wr_sel]<=DEPTH, wr_sel toggles, wr_idx<=0.
- Flush with wr_idx>0 and no completing accept: the bank closes with len = wr_idx, or wr_idx+1 if a sample is accepted the same cycle. full is set, wr_sel toggles, wr_idx<=0.
- Flush with wr_idx==0 and no accept: ignored.
- Flush in the same cycle as a completing accept: normal completion only, len=DEPTH.
- Output: out_valid = full[rd_sel]; out_bank = rd_sel; out_len = len[rd_sel] when valid, else 0.
- out_frame = bank[rd_sel] with samples at index ≥ out_len forced to 0.
- out_frame is 0 when !out_valid.
- Release (out_valid && out_ready): full[rd_sel]<=0, rd_sel toggles.
- Release and completion in the same cycle always target different banks; both take effect.
- Both banks full: in_ready=0. A release at edge N raises in_ready after edge N. There is no combinational out_ready→in_ready path.
- out_frame and out_len are stable while out_valid && !out_ready.

## Timing
- Last sample (or flush) accepted at edge N: out_valid=1 in cycle N+1 if rd_sel is that bank, else after the preceding frame is released.
- Throughput: one sample/cycle sustained, provided the consumer releases each frame within DEPTH cycles of it becoming valid.
- in_ready and out_valid are functions of registers only.
- Reset asserted mid-frame: partial data is discarded immediately; the first sample after deassertion is sample 0 of bank 0.

## Configuration
- PPBUF_DROP_EN undefined: backpressure mode as above; the drop_cnt port is absent.
- PPBUF_DROP_EN defined: in_ready is tied to 1.
  - A sample offered while full[wr_sel]=1 is discarded, and drop_cnt increments, saturating at 16'hFFFF.
  - Flush while full[wr_sel]=1 is ignored.
  - drop_cnt resets to 0.

## Test plan
- DATA_W=8, DEPTH=4; stream 0x11,0x22,0x33,0x44, out_ready=1 → out_valid one cycle after 0x44 with out_frame=32'h44332211, out_len=4, out_bank=0.
- Stream 8 samples 0x01..0x08 back-to-back, out_ready=0 → in_ready drops after the 8th sample. Raise out_ready for one cycle → frame 32'h04030201 released; next cycle out_frame=32'h08070605, out_bank=1, in_ready=1.
- Samples 0xA1,0xA2 then flush → out_len=2, out_frame=32'h0000A2A1. The next sample lands at index 0 of bank 1.
- Flush coincident with the 4th accepted sample → single frame with out_len=4; flush coincident with a 2nd sample 0xB2 after 0xB1 → out_len=2, out_frame=32'h0000B2B1.
- Assert rst_n=0 after 3 samples, release, send 4 new samples → only the new frame appears, out_bank=0.
- With PPBUF_DROP_EN, both banks full, offer 5 samples → in_ready stays 1, drop_cnt=5, and the banks are unchanged.

Source files
------------

// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf
//
// Purpose:
//   Ping-pong frame buffer. Collects a stream of DATA_W-bit samples into
//   DEPTH-sample frames, alternating between two banks, and presents each
//   completed frame as a single wide word under a valid/ready handshake.
//   Capture into one bank continues while the consumer holds the other.
//   A single-cycle flush closes a partially filled frame early.
//
// Build option:
//   PPBUF_DROP_EN - when defined, in_ready is tied high. Samples offered
//                   while the write bank is still full are discarded and
//                   counted on drop_cnt, which saturates at 16'hFFFF.
//                   When undefined, the buffer backpressures through
//                   in_ready and the drop_cnt port does not exist.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sample present
//   in_data    sample value
//   in_ready   sample accepted when in_valid && in_ready
//   flush      single-cycle request to close the current partial frame
//   out_valid  frame available
//   out_ready  consumer takes the frame when out_valid && out_ready
//   out_frame  sample k at bits [k*DATA_W +: DATA_W], zero beyond out_len
//   out_len    number of valid samples in out_frame (0 when !out_valid)
//   out_bank   bank index of the presented frame
//   drop_cnt   dropped-sample count (PPBUF_DROP_EN only)

module pingpong_frame_buf #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 512,
  parameter int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DEPTH*DATA_W-1:0] out_frame,
  output logic [LEN_W-1:0]        out_len,
  output logic                    out_bank
`ifdef PPBUF_DROP_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FRAME_W = DEPTH * DATA_W;

  logic [FRAME_W-1:0] bank0;
  logic [FRAME_W-1:0] bank1;
  logic [1:0]         full;
  logic [1:0]         full_next;
  logic [LEN_W-1:0]   len0;
  logic [LEN_W-1:0]   len1;
  logic               wr_sel;
  logic               rd_sel;
  logic [IDX_W-1:0]   wr_idx;

  logic               accept;
  logic               complete;
  logic               close_frame;
  logic [LEN_W-1:0]   close_len;
  logic               take_frame;
  logic [FRAME_W-1:0] rd_bank;
  logic [LEN_W-1:0]   rd_len;

  // Control decode. A sample is only ever written into a bank that is not
  // full, so the bank being presented can never be overwritten. A flush
  // closes the write bank whenever it holds at least one sample (counting a
  // sample accepted in the same cycle); a completing accept takes priority
  // and always yields a full-length frame. Closing and releasing can never
  // hit the same bank: closing needs the write bank empty-flagged, releasing
  // needs the read bank full-flagged.
  always_comb begin
    accept      = in_valid && !full[wr_sel];
    complete    = accept && (wr_idx == IDX_W'(DEPTH - 1));
    close_frame = complete ||
                  (flush && !full[wr_sel] && ((wr_idx != '0) || accept));
    close_len   = complete ? LEN_W'(DEPTH)
                           : LEN_W'(wr_idx) + LEN_W'(accept);
    take_frame  = full[rd_sel] && out_ready;
    full_next   = full;
    if (take_frame)  full_next[rd_sel] = 1'b0;
    if (close_frame) full_next[wr_sel] = 1'b1;
  end

  // Bank storage, fill pointer and bank selectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0  <= '0;
      bank1  <= '0;
      full   <= '0;
      len0   <= '0;
      len1   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_idx <= '0;
    end else begin
      if (accept) begin
        if (wr_sel) bank1[wr_idx*DATA_W +: DATA_W] <= in_data;
        else        bank0[wr_idx*DATA_W +: DATA_W] <= in_data;
      end
      if (close_frame) begin
        if (wr_sel) len1 <= close_len;
        else        len0 <= close_len;
        wr_idx <= '0;
      end else if (accept) begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
      full   <= full_next;
      wr_sel <= wr_sel ^ close_frame;
      rd_sel <= rd_sel ^ take_frame;
    end
  end

`ifdef PPBUF_DROP_EN
  // Count samples that arrive while the write bank is still occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_valid && full[wr_sel] && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign in_ready = 1'b1;
`else
  assign in_ready = !full[wr_sel];
`endif

  // Output view of the read bank. Stale samples beyond the frame length
  // (left over from an earlier, longer frame) are masked to zero so the
  // consumer sees a clean word after a flush.
  always_comb begin
    rd_bank   = rd_sel ? bank1 : bank0;
    rd_len    = rd_sel ? len1 : len0;
    out_valid = full[rd_sel];
    out_bank  = rd_sel;
    out_len   = out_valid ? rd_len : '0;
    out_frame = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (out_valid && (k < int'(rd_len))) begin
        out_frame[k*DATA_W +: DATA_W] = rd_bank[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// tb_pingpong_frame_buf
//
// Purpose:
//   Directed test of pingpong_frame_buf with DATA_W=8, DEPTH=4: basic
//   capture, backpressure with both banks full, flush (alone, coincident
//   with a partial accept and with a completing accept), ignored empty
//   flush, mid-frame reset and, when PPBUF_DROP_EN is defined, drop mode.

module tb_pingpong_frame_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    in_ready;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [DEPTH*DATA_W-1:0] out_frame;
  logic [LEN_W-1:0]        out_len;
  logic                    out_bank;
`ifdef PPBUF_DROP_EN
  logic [15:0]             drop_cnt;
`endif

  int vectors;
  int miscompares;

  pingpong_frame_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_frame(out_frame),
    .out_len  (out_len),
    .out_bank (out_bank)
`ifdef PPBUF_DROP_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let the rising edge happen and settle
  // 1 unit after it so outputs are sampled away from the edge.
  task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d,
                                input logic fl, input logic rdy);
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Hold reset across two edges, release it just after an edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    in_data     = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    rst_n       = 1'b1;
    #2;

    // Reset state
    do_reset();
    check_output("rst_in_ready",  32'(in_ready),  32'h1);
    check_output("rst_out_valid", 32'(out_valid), 32'h0);
    check_output("rst_out_frame", out_frame,      32'h0);
    check_output("rst_out_len",   32'(out_len),   32'h0);
    check_output("rst_out_bank",  32'(out_bank),  32'h0);
`ifdef PPBUF_DROP_EN
    check_output("rst_drop_cnt",  32'(drop_cnt),  32'h0);
`endif

    // Basic frame with the consumer ready
    $display("[TB] basic frame");
    apply_stimulus(1'b1, 8'h11, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'h22, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'h33, 1'b0, 1'b1);
    check_output("t1_not_yet_valid", 32'(out_valid), 32'h0);
    apply_stimulus(1'b1, 8'h44, 1'b0, 1'b1);
    check_output("t1_out_valid", 32'(out_valid), 32'h1);
    check_output("t1_out_frame", out_frame,      32'h44332211);
    check_output("t1_out_len",   32'(out_len),   32'h4);
    check_output("t1_out_bank",  32'(out_bank),  32'h0);
    check_output("t1_in_ready",  32'(in_ready),  32'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("t1_released_valid", 32'(out_valid), 32'h0);
    check_output("t1_released_frame", out_frame,      32'h0);

    // Both banks fill under backpressure
    $display("[TB] backpressure");
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 7) check_output("t2_in_ready_before_8th", 32'(in_ready), 32'h1);
    end
    check_output("t2_in_ready_full", 32'(in_ready),  32'h0);
    check_output("t2_frame0",        out_frame,      32'h04030201);
    check_output("t2_bank0",         32'(out_bank),  32'h0);
    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0);
    check_output("t2_hold_frame",    out_frame,      32'h04030201);
    check_output("t2_hold_in_ready", 32'(in_ready),  32'h0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("t2_frame1",        out_frame,      32'h08070605);
    check_output("t2_bank1",         32'(out_bank),  32'h1);
    check_output("t2_len1",          32'(out_len),   32'h4);
    check_output("t2_in_ready_back", 32'(in_ready),  32'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("t2_drained",       32'(out_valid), 32'h0);

    // Partial frame closed by flush; stale bank data must be masked
    $display("[TB] flush");
    apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("t3_valid", 32'(out_valid), 32'h1);
    check_output("t3_len",   32'(out_len),   32'h2);
    check_output("t3_frame", out_frame,      32'h0000A2A1);
    check_output("t3_bank",  32'(out_bank),  32'h0);
    apply_stimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
    check_output("t3_next_frame", out_frame,     32'h000000C1);
    check_output("t3_next_len",   32'(out_len),  32'h1);
    check_output("t3_next_bank",  32'(out_bank), 32'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("t3_empty_flush_valid", 32'(out_valid), 32'h0);
    check_output("t3_empty_flush_ready", 32'(in_ready),  32'h1);

    // Flush coincident with a completing accept and with a partial accept
    $display("[TB] flush with accept");
    apply_stimulus(1'b1, 8'hD1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hD2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hD3, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hD4, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hB2, 1'b1, 1'b0);
    check_output("t4_full_frame", out_frame,     32'hD4D3D2D1);
    check_output("t4_full_len",   32'(out_len),  32'h4);
    check_output("t4_both_full",  32'(in_ready), 32'h0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("t4_part_frame", out_frame,     32'h0000B2B1);
    check_output("t4_part_len",   32'(out_len),  32'h2);
    check_output("t4_part_bank",  32'(out_bank), 32'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame
    $display("[TB] mid-frame reset");
    apply_stimulus(1'b1, 8'hE1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hE2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hE3, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    check_output("t5_async_in_ready",  32'(in_ready),  32'h1);
    check_output("t5_async_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 8'h51, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h52, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h53, 1'b0, 1'b0);
    check_output("t5_no_stale_frame", 32'(out_valid), 32'h0);
    apply_stimulus(1'b1, 8'h54, 1'b0, 1'b0);
    check_output("t5_frame", out_frame,     32'h54535251);
    check_output("t5_bank",  32'(out_bank), 32'h0);
    check_output("t5_len",   32'(out_len),  32'h4);

`ifdef PPBUF_DROP_EN
    // Drop mode: offers against two full banks are discarded and counted
    $display("[TB] drop mode");
    do_reset();
    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0);
      check_output("t6_in_ready", 32'(in_ready), 32'h1);
    end
    in_valid = 1'b0;
    check_output("t6_drop_cnt", 32'(drop_cnt), 32'h5);
    check_output("t6_frame0",   out_frame,     32'h04030201);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("t6_frame1",   out_frame,     32'h08070605);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
